// File: rtl/main_memory_ctrl_pkg.sv
// Shared configuration for the main-memory backing store: widths, depth,
// access latencies and the controller state encoding.
package main_memory_config;

    localparam int MAIN_MEMORY_ADDRESS_WIDTH = 32;
    localparam int MAIN_MEMORY_DATA_WIDTH    = 128;
    localparam int MM_DEPTH                  = 1024;
    localparam int MM_READ_LATENCY           = 8;
    localparam int MM_WRITE_LATENCY          = 6;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        DONE       = 2'd3
    } mm_state_t;

    function automatic int mm_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/main_memory_ctrl_ram.sv
// Block storage: DEPTH x DATA_W, one write port and one registered read port.
// Contents are deliberately not reset so they survive a controller reset.
module mm_block_ram #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 128,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_idx];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency block memory controller behind the L1 miss path: one
// 128-bit read or write at a time, completion signalled by a one-cycle ready.
module main_memory_ctrl
    import main_memory_config::*;
#(
    parameter int ADDR_W        = MAIN_MEMORY_ADDRESS_WIDTH,
    parameter int DATA_W        = MAIN_MEMORY_DATA_WIDTH,
    parameter int DEPTH         = MM_DEPTH,
    parameter int READ_LATENCY  = MM_READ_LATENCY,
    parameter int WRITE_LATENCY = MM_WRITE_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              main_memory_read_request,
    input  logic              main_memory_write_request,
    input  logic [ADDR_W-1:0] main_memory_address,
    input  logic [DATA_W-1:0] main_memory_write_data,
    output logic [DATA_W-1:0] main_memory_read_data,
    output logic              main_memory_ready,
    output logic              main_memory_busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(mm_max(READ_LATENCY, WRITE_LATENCY)) + 1;

    mm_state_t         r_state;
    mm_state_t         w_next_state;
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_index;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_read_data;
    logic              r_ready;

    logic [IDX_W-1:0]  w_req_index;
    logic [IDX_W-1:0]  w_rd_index;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_accept_wr;
    logic              w_accept_rd;
    logic              w_finish;
    logic              w_ram_we;
    logic              w_unused_addr_bits;

    assign w_req_index        = main_memory_address[4 +: IDX_W];
    assign w_unused_addr_bits = ^{main_memory_address[ADDR_W-1:IDX_W+4], main_memory_address[3:0]};

    // In IDLE the RAM already reads the incoming index so the data is valid even for a one-cycle latency.
    assign w_rd_index = (r_state == IDLE) ? w_req_index : r_index;

    mm_block_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_ram_we),
        .i_wr_idx  (r_index),
        .i_wr_data (r_wdata),
        .i_rd_idx  (w_rd_index),
        .o_rd_data (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write takes priority when both requests arrive together: write-back precedes allocate.
    always_comb begin
        w_next_state = r_state;
        w_accept_wr  = 1'b0;
        w_accept_rd  = 1'b0;
        w_finish     = 1'b0;
        w_ram_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (main_memory_write_request) begin
                    w_accept_wr  = 1'b1;
                    w_next_state = WRITE_WAIT;
                end else if (main_memory_read_request) begin
                    w_accept_rd  = 1'b1;
                    w_next_state = READ_WAIT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            READ_WAIT: begin
                if (r_count == '0) begin
                    w_finish     = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_next_state = READ_WAIT;
                end
            end
            WRITE_WAIT: begin
                if (r_count == '0) begin
                    w_finish     = 1'b1;
                    w_ram_we     = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_next_state = WRITE_WAIT;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_ready     <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_ready <= w_finish;
            if (w_accept_wr) begin
                r_index <= w_req_index;
                r_wdata <= main_memory_write_data;
                r_count <= CNT_W'(WRITE_LATENCY - 1);
            end else if (w_accept_rd) begin
                r_index <= w_req_index;
                r_count <= CNT_W'(READ_LATENCY - 1);
            end else if (((r_state == READ_WAIT) || (r_state == WRITE_WAIT)) && (r_count != '0)) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_finish && (r_state == READ_WAIT)) begin
                r_read_data <= w_ram_rdata;
            end
        end
    end

    assign main_memory_read_data = r_read_data;
    assign main_memory_ready     = r_ready;
    assign main_memory_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl: latency, priority, aliasing and
// reset-abort behaviour with hand-computed expected blocks.
module tb_main_memory_ctrl;
    import main_memory_config::*;

    localparam logic [127:0] D_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] D_B = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D_C = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D_D = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] D_E = 128'hCAFEF00D_DEADBEEF_0BADC0DE_FEEDFACE;
    localparam logic [127:0] D_F = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    localparam logic [127:0] D_G = 128'h12121212_34343434_56565656_78787878;

    logic         clk;
    logic         reset;
    logic         rd_req;
    logic         wr_req;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         ready;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    main_memory_ctrl dut (
        .clk                       (clk),
        .reset                     (reset),
        .main_memory_read_request  (rd_req),
        .main_memory_write_request (wr_req),
        .main_memory_address       (addr),
        .main_memory_write_data    (wdata),
        .main_memory_read_data     (rdata),
        .main_memory_ready         (ready),
        .main_memory_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges after the accept edge until ready is seen, or -1.
    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (ready === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [127:0] d, output int lat);
        addr = a; wdata = d; wr_req = 1'b1;
        tick();
        wait_ready(lat);
        wr_req = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [127:0] blk);
        addr = a; rd_req = 1'b1;
        tick();
        wait_ready(lat);
        blk = rdata;
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (rdata !== 128'd0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    endtask

    task automatic test_write();
        int n;
        addr = 32'h0000_0040; wdata = D_A; wr_req = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL write_busy_accept: got %b expected 1", busy); end
        addr = 32'h0000_07F0; wdata = '1;
        wait_ready(n);
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL write_latency: got %0d expected 6", n); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL write_busy_ready: got %b expected 1", busy); end
        wr_req = 1'b0;
        tick();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL write_ready_width: got %b expected 0", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_after_done: got %b expected 0", busy); end
    endtask

    task automatic test_read();
        int n;
        logic [127:0] blk;
        do_read(32'h0000_0040, n, blk);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL read_latency: got %0d expected 8", n); end
        n_cmp++; if (blk !== D_A) begin n_bad++; $display("FAIL read_data: got %h expected %h", blk, D_A); end
        n_cmp++; if (blk[31:0] !== 32'hAAAA_AAAA) begin n_bad++; $display("FAIL read_word0: got %h expected aaaaaaaa", blk[31:0]); end
        tick(); tick();
        n_cmp++; if (rdata !== D_A) begin n_bad++; $display("FAIL read_data_held: got %h expected %h", rdata, D_A); end
    endtask

    task automatic test_reset_mid_read();
        int n;
        do_write(32'h0000_0200, D_B, n);
        addr = 32'h0000_0200; rd_req = 1'b1;
        tick();
        wait_ready(n);
        n_cmp++; if (rdata !== D_B) begin n_bad++; $display("FAIL rstrd_data: got %h expected %h", rdata, D_B); end
        reset = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rstrd_ready: got %b expected 0", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstrd_busy: got %b expected 0", busy); end
        n_cmp++; if (rdata !== 128'd0) begin n_bad++; $display("FAIL rstrd_rdata: got %h expected 0", rdata); end
        rd_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstrd_idle: got %b expected 0", busy); end
    endtask

    task automatic test_collision();
        int n;
        logic [31:0]  a_tab [2] = '{32'h0000_0080, 32'h0000_00C0};
        logic [127:0] d_tab [2] = '{D_C, D_D};
        for (int k = 0; k < 2; k++) begin
            addr = a_tab[k]; wdata = d_tab[k]; wr_req = 1'b1; rd_req = 1'b1;
            tick();
            wait_ready(n);
            n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL coll_write_first[%0d]: got latency %0d expected 6", k, n); end
            wr_req = 1'b0;
            tick();
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL coll_done_exit[%0d]: got busy %b expected 0", k, busy); end
            tick();
            wait_ready(n);
            n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL coll_read_latency[%0d]: got %0d expected 8", k, n); end
            n_cmp++; if (rdata !== d_tab[k]) begin n_bad++; $display("FAIL coll_read_data[%0d]: got %h expected %h", k, rdata, d_tab[k]); end
            rd_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_alias();
        int n;
        logic [127:0] blk;
        do_write(32'h0000_0040, D_E, n);
        do_read(32'h0000_0040 + 32'(MM_DEPTH * 16), n, blk);
        n_cmp++; if (blk !== D_E) begin n_bad++; $display("FAIL alias_wrap: got %h expected %h", blk, D_E); end
        do_read(32'h0000_004F, n, blk);
        n_cmp++; if (blk !== D_E) begin n_bad++; $display("FAIL alias_low_bits: got %h expected %h", blk, D_E); end
    endtask

    task automatic test_reset_mid_write();
        int n;
        logic seen;
        logic [127:0] blk;
        do_write(32'h0000_0100, D_F, n);
        addr = 32'h0000_0100; wdata = D_G; wr_req = 1'b1;
        tick();
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstwr_busy: got %b expected 0", busy); end
        wr_req = 1'b0;
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ready === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstwr_no_ready: got %b expected 0", seen); end
        do_read(32'h0000_0100, n, blk);
        n_cmp++; if (blk !== D_F) begin n_bad++; $display("FAIL rstwr_prior_contents: got %h expected %h", blk, D_F); end
    endtask

    initial begin
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = 32'd0; wdata = 128'd0;
        tick(); tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_write();
        test_read();
        test_reset_mid_read();
        test_collision();
        test_alias();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
